// File: rtl/clk_gate_en_ctrl.sv
// Enable controller for a latch-based clock gate.
// Sequences OFF -> WAKE -> ON -> DRAIN -> OFF with registered EN/ACK.
module clk_gate_en_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_busy,
  input  logic       i_force_on,
  output logic       o_en,
  output logic       o_ack,
  output logic [1:0] o_state
);

  localparam int WW = $clog2(WAKE_CYCLES) + 1;
  localparam int IW = $clog2(IDLE_CYCLES) + 1;

  localparam logic [WW-1:0] WAKE_LOAD =
    WW'(WAKE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST =
    IW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_WAKE  = 2'b01,
    S_ON    = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_wake_cnt;
  logic [WW-1:0] w_wake_nxt;
  logic [IW-1:0] r_idle_cnt;
  logic [IW-1:0] w_idle_nxt;
  logic          r_en;
  logic          r_ack;
  logic          w_act;

  assign w_act = i_req | i_busy | i_force_on;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_OFF;
      r_wake_cnt <= '0;
      r_idle_cnt <= '0;
      r_en       <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_en       <= (w_state_nxt != S_OFF);
      r_ack      <= (w_state_nxt == S_ON);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wake_nxt  = r_wake_cnt;
    w_idle_nxt  = r_idle_cnt;
    unique case (r_state)
      S_OFF: begin
        if (w_act) begin
          w_state_nxt = S_WAKE;
          w_wake_nxt  = WAKE_LOAD;
        end
      end
      S_WAKE: begin
        // WAKE always completes; activity is ignored here.
        if (r_wake_cnt == '0) begin
          w_state_nxt = S_ON;
          w_idle_nxt  = '0;
        end else begin
          w_wake_nxt = r_wake_cnt - 1'b1;
        end
      end
      S_ON: begin
        if (w_act) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_act) begin
          w_state_nxt = S_ON;
          w_idle_nxt  = '0;
        end else begin
          w_state_nxt = S_OFF;
        end
      end
      default: begin
        w_state_nxt = S_OFF;
      end
    endcase
  end

  assign o_en    = r_en;
  assign o_ack   = r_ack;
  assign o_state = r_state;

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// Directed bench for clk_gate_en_ctrl.
// IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clk_gate_en_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       busy;
  logic       force_on;
  logic       en;
  logic       ack;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  clk_gate_en_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_busy     (busy),
    .i_force_on (force_on),
    .o_en       (en),
    .o_ack      (ack),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_s(input string tag,
                          input logic [1:0] s,
                          input logic e,
                          input logic a);
    chk({tag, ".state"}, 8'(state), 8'(s));
    chk({tag, ".en"}, 8'(en), 8'(e));
    chk({tag, ".ack"}, 8'(ack), 8'(a));
  endtask

  // One-cycle REQ from OFF; full wake/idle/drain timeline.
  task automatic run_pulse(input string tag);
    req = 1'b1;
    tick();
    expect_s({tag, ".t1"}, 2'b01, 1'b1, 1'b0);
    req = 1'b0;
    tick();
    expect_s({tag, ".t2"}, 2'b01, 1'b1, 1'b0);
    tick();
    expect_s({tag, ".t3"}, 2'b10, 1'b1, 1'b1);
    for (int i = 4; i <= 6; i++) begin
      tick();
      expect_s({tag, ".on"}, 2'b10, 1'b1, 1'b1);
    end
    tick();
    expect_s({tag, ".t7"}, 2'b11, 1'b1, 1'b0);
    tick();
    expect_s({tag, ".t8"}, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic wake_to_on(input string tag);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    expect_s({tag, ".on"}, 2'b10, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 1'b1;
    busy = 1'b1;
    force_on = 1'b1;

    // 1: reset dominates full activity
    tick();
    expect_s("rst1", 2'b00, 1'b0, 1'b0);
    tick();
    expect_s("rst2", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    expect_s("rst_rel", 2'b01, 1'b1, 1'b0);
    req = 1'b0;
    busy = 1'b0;
    force_on = 1'b0;
    tick();
    expect_s("rst_w2", 2'b01, 1'b1, 1'b0);
    tick();
    expect_s("rst_on", 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    tick();
    expect_s("rst_drain", 2'b11, 1'b1, 1'b0);
    tick();
    expect_s("rst_off", 2'b00, 1'b0, 1'b0);

    // 2: single REQ pulse
    tick();
    expect_s("idle_off", 2'b00, 1'b0, 1'b0);
    run_pulse("pulse");

    // 3: BUSY held 20 cycles in ON, REQ+BUSY together at start
    wake_to_on("busy");
    req = 1'b1;
    busy = 1'b1;
    tick();
    chk("busy.ack0", 8'(ack), 8'd1);
    req = 1'b0;
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("busy.ack", 8'(ack), 8'd1);
    end
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_s("busy.idle", 2'b10, 1'b1, 1'b1);
    end
    tick();
    expect_s("busy.drain", 2'b11, 1'b1, 1'b0);
    tick();
    expect_s("busy.off", 2'b00, 1'b0, 1'b0);

    // 4: REQ in DRAIN resumes ON with cleared idle count
    wake_to_on("drq");
    for (int i = 0; i < 3; i++) tick();
    tick();
    expect_s("drq.drain", 2'b11, 1'b1, 1'b0);
    req = 1'b1;
    tick();
    expect_s("drq.back", 2'b10, 1'b1, 1'b1);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_s("drq.idle", 2'b10, 1'b1, 1'b1);
    end
    tick();
    expect_s("drq.drain2", 2'b11, 1'b1, 1'b0);
    tick();
    expect_s("drq.off", 2'b00, 1'b0, 1'b0);

    // 5: FORCE_ON holds ON
    force_on = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i < 3) begin
        chk("force.wake", 8'(state), 8'd1);
      end else begin
        chk("force.ack", 8'(ack), 8'd1);
        chk("force.st", 8'(state), 8'd2);
      end
    end
    force_on = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("force.en_hold", 8'(en), 8'd1);
    end
    tick();
    chk("force.en_off", 8'(en), 8'd0);
    chk("force.st_off", 8'(state), 8'd0);

    // 6: reset in second WAKE cycle
    req = 1'b1;
    tick();
    expect_s("rw.w1", 2'b01, 1'b1, 1'b0);
    req = 1'b0;
    tick();
    expect_s("rw.w2", 2'b01, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_s("rw.rst", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    expect_s("rw.post", 2'b00, 1'b0, 1'b0);
    run_pulse("rw.pulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
